// File: rtl/star_box_sequencer_pkg.sv
// star_pkg: shared sizes, image resolution and sequencer state encoding
// for the star bounding-box pipeline.
package star_pkg;

  // Default coordinate widths for a 160x120 image.
  localparam int XSZ_DEF = 8;
  localparam int YSZ_DEF = 7;
  localparam int X_RES   = 160;
  localparam int Y_RES   = 120;

  // Sequencer state encoding (3 bits).
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START_TB = 3'd1;
  localparam logic [2:0] ST_WAIT_TB  = 3'd2;
  localparam logic [2:0] ST_START_LR = 3'd3;
  localparam logic [2:0] ST_WAIT_LR  = 3'd4;
  localparam logic [2:0] ST_EMIT     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_START_TB = ST_START_TB,
    S_WAIT_TB  = ST_WAIT_TB,
    S_START_LR = ST_START_LR,
    S_WAIT_LR  = ST_WAIT_LR,
    S_EMIT     = ST_EMIT
  } seqState_t;

endpackage

// File: rtl/star_box_sequencer_found_capture.sv
// found_capture: sticky done flag plus data register for one column mapper.
// A clear wins over a simultaneous pulse; pulses are taken only while enabled.
module found_capture #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         en,
  input  logic         pulse,
  input  logic [W-1:0] data,
  output logic         done,
  output logic [W-1:0] q
);

  // Sticky flag set by an enabled pulse, data latched alongside it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done <= 1'b0;
      q    <= '0;
    end else if (clr) begin
      done <= 1'b0;
    end else if (en && pulse) begin
      done <= 1'b1;
      q    <= data;
    end
  end

endmodule

// File: rtl/star_box_sequencer.sv
// star_box_sequencer: schedules top/bottom then left/right mapping for one
// seed pixel and hands the finished box to the consumer over valid/ready.
// Optional watchdog on the wait states: define SEQ_TIMEOUT_EN.
module star_box_sequencer
  import star_pkg::*;
#(
  parameter int          XSZ            = XSZ_DEF,
  parameter int          YSZ            = YSZ_DEF,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           star_valid,
  input  logic [XSZ-1:0] star_x,
  input  logic [YSZ-1:0] star_y,
  output logic           star_ready,
  output logic [YSZ-1:0] seed_y,
  output logic           go_map_tb,
  input  logic           tb_found,
  input  logic [YSZ-1:0] most_top,
  input  logic [YSZ-1:0] most_bottom,
  output logic [XSZ-1:0] mid_pix,
  output logic           go_map_l,
  output logic           go_map_r,
  input  logic           left_found,
  input  logic           right_found,
  input  logic [XSZ-1:0] most_left,
  input  logic [XSZ-1:0] most_right,
  output logic           box_valid,
  input  logic           box_ready,
  output logic [XSZ-1:0] box_left,
  output logic [XSZ-1:0] box_right,
  output logic [YSZ-1:0] box_top,
  output logic [YSZ-1:0] box_bottom,
  output logic           busy,
  output logic           box_drop,
  output logic           timeout
);

  localparam int NCAP = 2;  // lane 0 = left, lane 1 = right

  seqState_t state, stateNxt;
  logic      dropNow, toNow, toHit;
  logic      capClr, capEn;

  logic [NCAP-1:0]          capPulse, capDone;
  logic [NCAP-1:0][XSZ-1:0] capData, capQ;

  assign capPulse = {right_found, left_found};
  assign capData  = {most_right, most_left};
  assign capClr   = (state == S_START_TB);
  assign capEn    = (state == S_START_LR) || (state == S_WAIT_LR);

  for (genvar i = 0; i < NCAP; i++) begin : gCap
    found_capture #(.W(XSZ)) uCap (
      .clk    (clk),
      .resetn (resetn),
      .clr    (capClr),
      .en     (capEn),
      .pulse  (capPulse[i]),
      .data   (capData[i]),
      .done   (capDone[i]),
      .q      (capQ[i])
    );
  end

  assign box_left  = capQ[0];
  assign box_right = capQ[1];

`ifdef SEQ_TIMEOUT_EN
  logic [15:0] waitCnt;

  // Per-phase watchdog: zeroed on the start state preceding each wait.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      waitCnt <= '0;
    else if (state == S_START_TB || state == S_START_LR)
      waitCnt <= '0;
    else if (state == S_WAIT_TB || state == S_WAIT_LR)
      waitCnt <= waitCnt + 16'd1;
  end

  assign toHit = (waitCnt == TIMEOUT_CYCLES - 16'd1);
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
  assign toHit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= stateNxt;
  end

  // Next state plus drop/timeout decisions.
  always_comb begin
    stateNxt = state;
    dropNow  = 1'b0;
    toNow    = 1'b0;
    case (state)
      S_IDLE:     if (star_valid) stateNxt = S_START_TB;
      S_START_TB: stateNxt = S_WAIT_TB;
      S_WAIT_TB: begin
        if (tb_found) begin
          if (most_bottom < most_top) begin
            dropNow  = 1'b1;
            stateNxt = S_IDLE;
          end else begin
            stateNxt = S_START_LR;
          end
        end else if (toHit) begin
          dropNow  = 1'b1;
          toNow    = 1'b1;
          stateNxt = S_IDLE;
        end
      end
      S_START_LR: stateNxt = S_WAIT_LR;
      S_WAIT_LR: begin
        if (&capDone) begin
          if (box_left > box_right) begin
            dropNow  = 1'b1;
            stateNxt = S_IDLE;
          end else begin
            stateNxt = S_EMIT;
          end
        end else if (toHit) begin
          dropNow  = 1'b1;
          toNow    = 1'b1;
          stateNxt = S_IDLE;
        end
      end
      S_EMIT:     if (box_ready) stateNxt = S_IDLE;
      default:    stateNxt = S_IDLE;
    endcase
  end

  // Seed latch on acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mid_pix <= '0;
      seed_y  <= '0;
    end else if (state == S_IDLE && star_valid) begin
      mid_pix <= star_x;
      seed_y  <= star_y;
    end
  end

  // Top/bottom capture on the mapper's done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      box_top    <= '0;
      box_bottom <= '0;
    end else if (state == S_WAIT_TB && tb_found) begin
      box_top    <= most_top;
      box_bottom <= most_bottom;
    end
  end

  // Seed is never acknowledged while reset is held.
  assign star_ready = (state == S_IDLE) && resetn;
  assign go_map_tb  = (state == S_START_TB);
  assign go_map_l   = (state == S_START_LR);
  assign go_map_r   = (state == S_START_LR);
  assign box_valid  = (state == S_EMIT);
  assign busy       = (state != S_IDLE);
  assign box_drop   = dropNow;
  assign timeout    = toNow;

endmodule
